// File: rtl/cache_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_access_ctrl
//  Purpose  : Serialises requester reads/writes onto an N-way cache and its
//             backing memory. Reads look up the cache and fill it on a miss.
//             Writes go through to memory and allocate in the cache.
//             Keeps saturating read hit/miss statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_access_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_hit,
  output logic                  cache_re,
  output logic                  cache_we,
  output logic [ADDR_WIDTH-1:0] cache_read_addr,
  output logic [ADDR_WIDTH-1:0] cache_write_addr,
  output logic [DATA_WIDTH-1:0] cache_in,
  input  logic [DATA_WIDTH-1:0] cache_out,
  input  logic                  cache_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] hit_cnt,
  output logic [STAT_WIDTH-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MEM_RD   = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_MEM_WR   = 3'd4
  } state_t;

  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_hit_q, rsp_hit_d;
  logic [STAT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
  logic [STAT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;
  logic                    hit_inc, miss_inc;

  // State, latched request and registered response/statistics.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Next-state and strobe decode; strobes and their payloads idle at zero.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rsp_valid_d      = 1'b0;
    rsp_data_d       = '0;
    rsp_hit_d        = 1'b0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    req_ready        = 1'b0;
    cache_re         = 1'b0;
    cache_read_addr  = '0;
    cache_we         = 1'b0;
    cache_write_addr = '0;
    cache_in         = '0;
    mem_req_valid    = 1'b0;
    mem_req_we       = 1'b0;
    mem_req_addr     = '0;
    mem_req_wdata    = '0;
    case (state_q)
      S_IDLE: begin
        // Gated by rstn so nothing is offered while reset is held.
        req_ready = rstn;
        if (req_valid && rstn) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_we) begin
            state_d = S_MEM_WR;
          end else begin
            cache_re        = 1'b1;
            cache_read_addr = req_addr;
            state_d         = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (cache_hit) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = cache_out;
          rsp_hit_d   = 1'b1;
          hit_inc     = 1'b1;
          state_d     = S_IDLE;
        end else begin
          miss_inc = 1'b1;
          state_d  = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
        if (mem_req_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_rsp_valid) begin
          cache_we         = 1'b1;
          cache_write_addr = addr_q;
          cache_in         = mem_rsp_data;
          rsp_valid_d      = 1'b1;
          rsp_data_d       = mem_rsp_data;
          state_d          = S_IDLE;
        end
      end
      S_MEM_WR: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        if (mem_req_ready) begin
          cache_we         = 1'b1;
          cache_write_addr = addr_q;
          cache_in         = wdata_q;
          rsp_valid_d      = 1'b1;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating statistics; a clear beats a coincident increment.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (stat_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (hit_inc && (hit_cnt_q != STAT_MAX))   hit_cnt_d  = hit_cnt_q + 1'b1;
      if (miss_inc && (miss_cnt_q != STAT_MAX)) miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_access_ctrl
//  Purpose  : Cycle-driven bench for cache_access_ctrl with transaction-level
//             cache, memory and requester models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_access_ctrl;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int SW   = 2;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_hit;
  logic [DW-1:0] rsp_data;
  logic          cache_re, cache_we;
  logic [AW-1:0] cache_read_addr, cache_write_addr;
  logic [DW-1:0] cache_in, cache_out;
  logic          cache_hit;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic          stat_clr;
  logic [SW-1:0] hit_cnt, miss_cnt;

  cache_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .cache_re(cache_re), .cache_we(cache_we),
    .cache_read_addr(cache_read_addr), .cache_write_addr(cache_write_addr),
    .cache_in(cache_in), .cache_out(cache_out), .cache_hit(cache_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .stat_clr(stat_clr),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  // Environment state: backing memory, cache contents, requester queue.
  logic [DW-1:0] mem_m [256];
  bit            cvalid[256];
  logic [DW-1:0] cdata [256];
  req_t          dq[$];
  req_t          cur;
  bit            req_pend;

  // Outstanding-transaction expectations.
  int            cyc;
  bit            active;
  logic          t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  int            acc, mreq_start, exp_rsp_cyc;
  bit            mreq_done;
  logic [DW-1:0] exp_rdata;
  logic          exp_rhit;
  bit            rd_pend;
  logic [AW-1:0] rd_addr;
  int            rd_due;
  int            e_hit, e_miss;
  bit            prev_cre;
  logic [AW-1:0] prev_caddr;

  // Knobs.
  bit rand_en, evict_en, stray_en, stray_force, clr_rand, clr_lookup;
  int force_ready, force_lat;

  int n_cmp, n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    dq.push_back(r);
  endtask

  // One clock cycle: drive environment inputs, let logic settle, compare, advance.
  task automatic step();
    bit            acc_now, lk, lk_hit, exp_mrv, hs, exp_cwe;
    logic [AW-1:0] ca, rd_a;
    logic [DW-1:0] cd;
    int            nh, nm;
    lk = 0; lk_hit = 0; exp_cwe = 0; ca = '0; cd = '0;

    // cache answers the previous cycle's lookup
    if (prev_cre) begin
      cache_hit = cvalid[prev_caddr];
      cache_out = cvalid[prev_caddr] ? cdata[prev_caddr] : DW'($urandom);
    end else begin
      cache_hit = 1'($urandom);
      cache_out = DW'($urandom);
    end
    mem_req_ready = (force_ready < 0) ? 1'($urandom) : force_ready[0];
    if (rd_pend && cyc == rd_due) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_m[rd_addr];
    end else if (!rd_pend && (stray_force || (stray_en && $urandom_range(0, 9) == 0))) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = DW'($urandom);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = DW'($urandom);
    end
    if (!req_pend) begin
      if (dq.size() > 0) begin
        cur = dq.pop_front(); req_pend = 1;
      end else if (rand_en && $urandom_range(0, 2) == 0) begin
        cur.we    = ($urandom_range(0, 3) == 0);
        cur.addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
        cur.wdata = DW'($urandom);
        req_pend  = 1;
      end
    end
    req_valid = req_pend;
    req_we    = req_pend ? cur.we    : 1'($urandom);
    req_addr  = req_pend ? cur.addr  : AW'($urandom);
    req_wdata = req_pend ? cur.wdata : DW'($urandom);
    stat_clr  = (clr_lookup && active && !t_we && cyc == acc + 1) ||
                (clr_rand && $urandom_range(0, 39) == 0);
    #1;

    // response and statistics
    check("rsp_valid", rsp_valid, (active && cyc == exp_rsp_cyc));
    if (active && cyc == exp_rsp_cyc) begin
      check("rsp_data", rsp_data, exp_rdata);
      check("rsp_hit", rsp_hit, exp_rhit);
      active = 0;
    end
    check("hit_cnt", hit_cnt, e_hit);
    check("miss_cnt", miss_cnt, e_miss);
    check("req_ready", req_ready, !active);

    // lookup strobe
    acc_now = req_valid && !active;
    check("cache_re", cache_re, acc_now && !req_we);
    check("cache_read_addr", cache_read_addr, (acc_now && !req_we) ? req_addr : '0);

    // lookup outcome is decided the cycle after acceptance
    if (active && !t_we && cyc == acc + 1) begin
      lk = 1; lk_hit = cache_hit;
      if (cache_hit) begin
        exp_rsp_cyc = cyc + 1; exp_rdata = cache_out; exp_rhit = 1'b1;
      end else begin
        mreq_start = cyc + 1;
      end
    end

    // memory response fills the cache
    if (rd_pend && cyc == rd_due) begin
      rd_a = rd_addr;
      exp_cwe = 1; ca = rd_a; cd = mem_m[rd_a];
      exp_rsp_cyc = cyc + 1; exp_rdata = mem_m[rd_a]; exp_rhit = 1'b0;
      rd_pend = 0;
    end

    // memory request channel
    exp_mrv = active && !mreq_done && mreq_start >= 0 && cyc >= mreq_start;
    check("mem_req_valid", mem_req_valid, exp_mrv);
    check("mem_req_we", mem_req_we, exp_mrv && t_we);
    check("mem_req_addr", mem_req_addr, exp_mrv ? t_addr : '0);
    check("mem_req_wdata", mem_req_wdata, (exp_mrv && t_we) ? t_wdata : '0);
    hs = exp_mrv && mem_req_ready;
    if (hs) begin
      mreq_done = 1;
      if (t_we) begin
        mem_m[t_addr] = t_wdata;
        exp_cwe = 1; ca = t_addr; cd = t_wdata;
        exp_rsp_cyc = cyc + 1; exp_rdata = '0; exp_rhit = 1'b0;
      end else begin
        rd_pend = 1; rd_addr = t_addr;
        rd_due  = cyc + ((force_lat > 0) ? force_lat : $urandom_range(1, 4));
      end
    end

    check("cache_we", cache_we, exp_cwe);
    check("cache_write_addr", cache_write_addr, ca);
    check("cache_in", cache_in, cd);
    if (exp_cwe) begin
      cvalid[ca] = 1; cdata[ca] = cd;
    end

    // acceptance
    if (acc_now) begin
      active = 1; t_we = req_we; t_addr = req_addr; t_wdata = req_wdata;
      acc = cyc; mreq_done = 0; exp_rsp_cyc = -1;
      mreq_start = req_we ? cyc + 1 : -1;
      req_pend = 0;
    end
    if (active && cyc - acc > 200) begin
      check("txn_timeout", 1, 0);
      active = 0; rd_pend = 0;
    end

    // statistics model
    nh = e_hit; nm = e_miss;
    if (lk) begin
      if (lk_hit) nh = (e_hit + 1 > SMAX) ? SMAX : e_hit + 1;
      else        nm = (e_miss + 1 > SMAX) ? SMAX : e_miss + 1;
    end
    if (stat_clr) begin nh = 0; nm = 0; end
    e_hit = nh; e_miss = nm;

    if (evict_en && $urandom_range(0, 15) == 0) cvalid[$urandom_range(0, 255)] = 0;
    prev_cre   = cache_re;
    prev_caddr = cache_read_addr;

    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((active || req_pend || dq.size() > 0) && n < 300) begin
      step(); n++;
    end
    if (n >= 300) check("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    active = 0; rd_pend = 0; req_pend = 0; prev_cre = 0; mreq_done = 0;
    acc = 0; mreq_start = -1; exp_rsp_cyc = -1; e_hit = 0; e_miss = 0;
    rand_en = 0; evict_en = 0; stray_en = 0; stray_force = 0;
    clr_rand = 0; clr_lookup = 0; force_ready = 1; force_lat = 3;
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = DW'($urandom); cvalid[i] = 0; cdata[i] = '0;
    end
    mem_m[8'h12] = 8'hA5;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    cache_hit = 0; cache_out = '0; mem_req_ready = 0; mem_rsp_valid = 0;
    mem_rsp_data = '0; stat_clr = 0;

    // reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_cache_we", cache_we, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    check("rel_req_ready", req_ready, 1);

    // cold read miss, memory answers after 3 cycles
    push(0, 8'h12, 8'h00);
    wait_idle();
    check("dir_miss_cnt", miss_cnt, 1);
    // read again: hit
    push(0, 8'h12, 8'h00);
    wait_idle();
    check("dir_hit_cnt", hit_cnt, 1);

    // write with memory stalled for 4 cycles, then read-after-write hit
    force_ready = 0;
    push(1, 8'h34, 8'h5C);
    repeat (5) step();
    force_ready = 1;
    wait_idle();
    push(0, 8'h34, 8'h00);
    wait_idle();

    // request held valid across a miss
    cvalid[8'h40] = 0;
    force_lat = 2;
    push(0, 8'h40, 8'h00);
    push(0, 8'h12, 8'h00);
    wait_idle();

    // saturation
    for (int i = 0; i < 4; i++) push(0, 8'h12, 8'h00);
    wait_idle();
    check("dir_hit_sat", hit_cnt, SMAX);

    // clear coinciding with a hit
    clr_lookup = 1;
    push(0, 8'h12, 8'h00);
    wait_idle();
    clr_lookup = 0;
    check("dir_clr_hit", hit_cnt, 0);

    // reset while waiting on memory, then a stray memory response
    cvalid[8'h77] = 0;
    force_lat = 6;
    push(0, 8'h77, 8'h00);
    for (int i = 0; i < 50 && !rd_pend; i++) step();
    step(); step();
    rstn = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_cache_we", cache_we, 0);
    check("mrst_mem_req_valid", mem_req_valid, 0);
    check("mrst_miss_cnt", miss_cnt, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    active = 0; rd_pend = 0; req_pend = 0; prev_cre = 0; e_hit = 0; e_miss = 0;
    stray_force = 1;
    step();
    stray_force = 0;
    step(); step();

    // randomized traffic
    rand_en = 1; evict_en = 1; stray_en = 1; clr_rand = 1;
    force_ready = -1; force_lat = 0;
    repeat (3000) step();
    rand_en = 0;
    wait_idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_access_ctrl.md
# cache_access_ctrl

Sequencer that sits in front of the generic N-way cache and serialises requester accesses onto it and onto backing memory. Reads look up the cache; on a miss it fetches the word from memory, fills the cache and returns the data. Writes are write-through with allocate: memory is updated and the cache line is written in the same cycle. It also keeps saturating hit/miss statistics for performance monitoring.

## Interface
- ADDR_WIDTH, 8, address width; equals the cache's CACHE_ADDR_WIDTH
- DATA_WIDTH, 8, data width; equals the cache's CACHE_DATA_WIDTH
- STAT_WIDTH, 16, width of each statistics counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_data  out  DATA_WIDTH  read data; 0 for write acks
- rsp_hit  out  1  response served from cache
- cache_re / cache_we  out  1  cache read/write enables
- cache_read_addr / cache_write_addr  out  ADDR_WIDTH  cache addresses
- cache_in  out  DATA_WIDTH  cache write data
- cache_out  in  DATA_WIDTH  cache read data, valid the cycle after cache_re
- cache_hit  in  1  cache hit, valid the cycle after cache_re
- mem_req_valid  out  1  memory request, held until accepted
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  memory write
- mem_req_addr  out  ADDR_WIDTH  memory address
- mem_req_wdata  out  DATA_WIDTH  memory write data
- mem_rsp_valid  in  1  memory read data valid, one cycle
- mem_rsp_data  in  DATA_WIDTH  memory read data
- stat_clr  in  1  synchronous clear of both counters
- hit_cnt / miss_cnt  out  STAT_WIDTH  saturating read-hit and read-miss counts

## Operation
- States: IDLE, LOOKUP, MEM_RD, MEM_WAIT, MEM_WR.
- IDLE: req_ready=1; all other strobes 0. On req_valid, latch addr, we and wdata. For a read, drive cache_re=1 and cache_read_addr=req_addr combinationally in the same cycle, then go to LOOKUP. For a write, go to MEM_WR.
- LOOKUP: sample cache_hit and cache_out.
  - Hit: register rsp_valid=1, rsp_data=cache_out, rsp_hit=1; hit_cnt+1; go to IDLE.
  - Miss: miss_cnt+1; go to MEM_RD.
- MEM_RD: mem_req_valid=1, mem_req_we=0, mem_req_addr=latched addr. Hold these until mem_req_ready, then go to MEM_WAIT.
- MEM_WAIT: wait for mem_rsp_valid. In that cycle:
  - drive cache_we=1, cache_write_addr=latched addr, cache_in=mem_rsp_data;
  - register rsp_valid=1, rsp_data=mem_rsp_data, rsp_hit=0;
  - go to IDLE.
- MEM_WR: mem_req_valid=1, mem_req_we=1, with latched addr and data. In the mem_req_ready cycle:
  - drive cache_we=1 with the same addr and data;
  - register rsp_valid=1, rsp_data=0, rsp_hit=0;
  - go to IDLE.
- req_ready is 0 in every state except IDLE. Only one transaction is outstanding at a time.
- Counters saturate at all-ones. If stat_clr coincides with an increment, the clear wins (result 0). Writes are not counted.
- mem_req_* outputs are 0 whenever mem_req_valid=0. cache addresses and cache_in are 0 whenever their enable is 0.

## Timing
- Reset (asynchronous, any state): state=IDLE; rsp_valid=0, rsp_data=0, rsp_hit=0; hit_cnt=0, miss_cnt=0; every strobe output 0. req_ready=1 once rstn is released. An in-flight memory transaction is abandoned; memory is reset together with this block.
- Read hit: accept in cycle T; LOOKUP in T+1; rsp_valid in T+2. Next acceptance is possible in T+2.
- Read miss: mem_req_valid rises in T+2. If ready and response are immediate, rsp_valid comes one cycle after the mem_rsp_valid cycle.
- Write: mem_req_valid in T+1; rsp_valid in the cycle after mem_req_ready.
- A cache fill at edge E is visible to a lookup issued in the IDLE cycle after E, so read-after-write to the same address hits.
- mem_rsp_valid outside MEM_WAIT is ignored.

## Test plan
- Reset, then read 0x12 on a cold cache → cache miss, mem read of 0x12; memory returns 0xA5 after 3 cycles → cache_we with addr 0x12 / data 0xA5, rsp_data=0xA5, rsp_hit=0, miss_cnt=1.
- Read 0x12 again → rsp_valid exactly 2 cycles after acceptance, rsp_data=0xA5, rsp_hit=1, no mem_req_valid, hit_cnt=1.
- Write 0x34←0x5C with mem_req_ready low for 4 cycles → mem_req_valid and mem_req_addr stable throughout; single cache_we and rsp_valid after ready. A following read of 0x34 → hit, returns 0x5C.
- req_valid held high during a miss → req_ready=0 until the response; the second request is accepted the cycle rsp_valid pulses.
- With STAT_WIDTH=2, four read hits → hit_cnt=3 (saturated). stat_clr asserted on a hit cycle → hit_cnt=0.
- rstn asserted in MEM_WAIT → outputs zero immediately; a stray mem_rsp_valid after release → no rsp_valid, no cache_we.
